// File: rtl/udl_mod_counter_if.sv
// Control, data and status signals of the up/down/load modulus counter.
// master drives the controls and observes status; slave is the counter itself.
interface udl_mod_counter_if #(
  parameter int BITS   = 8,
  parameter int STEP_W = 4
);
  logic              clear;
  logic              enable;
  logic              up;
  logic              load;
  logic              mode;
  logic [BITS-1:0]   d;
  logic [BITS-1:0]   limit;
  logic [STEP_W-1:0] step;
  logic [BITS-1:0]   q;
  logic              wrap_evt;
  logic              at_max;
  logic              at_min;
  logic              tc;

  modport master (
    output clear, enable, up, load, mode, d, limit, step,
    input  q, wrap_evt, at_max, at_min, tc
  );

  modport slave (
    input  clear, enable, up, load, mode, d, limit, step,
    output q, wrap_evt, at_max, at_min, tc
  );
endinterface

// File: rtl/udl_mod_counter.sv
// Up/down/load counter over 0..limit with programmable step, wrap or saturate.
// Latency: one clock to q/wrap_evt; at_max/at_min/tc follow q combinationally.
// Backpressure: none, every edge is an update; controls are sampled each edge.
module udl_mod_counter #(
  parameter int BITS   = 8,
  parameter int STEP_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  udl_mod_counter_if.slave      bus
);
  localparam int CW = ((BITS > STEP_W) ? BITS : STEP_W) + 1;

  logic [BITS-1:0] q_r;
  logic            evt_r;
  logic [BITS-1:0] q_nxt;
  logic            evt_nxt;

  logic [CW-1:0]   step_ext;
  logic [CW-1:0]   limit_ext;
  logic [BITS:0]   s_x;
  logic [BITS:0]   q_x;
  logic [BITS:0]   lim_x;
  logic [BITS:0]   lim_p1;
  logic [BITS:0]   sum_up;
  logic [BITS:0]   wrap_up;
  logic [BITS:0]   diff_dn;
  logic [BITS:0]   wrap_dn;
  logic            at_max;
  logic            at_min;

  // Clamping the step to limit keeps every result inside one modulus period.
  assign step_ext  = CW'(bus.step);
  assign limit_ext = CW'(bus.limit);
  assign s_x       = (step_ext > limit_ext) ? {1'b0, bus.limit} : step_ext[BITS:0];

  assign q_x     = {1'b0, q_r};
  assign lim_x   = {1'b0, bus.limit};
  assign lim_p1  = lim_x + (BITS+1)'(1);
  assign sum_up  = q_x + s_x;
  assign wrap_up = sum_up - lim_p1;
  assign diff_dn = q_x - s_x;
  assign wrap_dn = q_x + lim_p1 - s_x;

  always_comb begin
    q_nxt   = q_r;
    evt_nxt = 1'b0;
    if (bus.clear) begin
      q_nxt = '0;
    end else if (bus.load) begin
      q_nxt = (bus.d > bus.limit) ? bus.limit : bus.d;
    end else if (bus.enable) begin
      if (q_r > bus.limit) begin
        q_nxt = bus.limit;
      end else if (s_x != '0) begin
        if (bus.up) begin
          if (sum_up > lim_x) begin
            if (bus.mode) begin
              q_nxt   = bus.limit;
              evt_nxt = (q_r != bus.limit);
            end else begin
              q_nxt   = wrap_up[BITS-1:0];
              evt_nxt = 1'b1;
            end
          end else begin
            q_nxt = sum_up[BITS-1:0];
          end
        end else begin
          if (q_x < s_x) begin
            if (bus.mode) begin
              q_nxt   = '0;
              evt_nxt = (q_r != '0);
            end else begin
              q_nxt   = wrap_dn[BITS-1:0];
              evt_nxt = 1'b1;
            end
          end else begin
            q_nxt = diff_dn[BITS-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r   <= '0;
      evt_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      evt_r <= evt_nxt;
    end
  end

  assign at_max       = (q_r == bus.limit);
  assign at_min       = (q_r == '0);
  assign bus.q        = q_r;
  assign bus.wrap_evt = evt_r;
  assign bus.at_max   = at_max;
  assign bus.at_min   = at_min;
  // Terminal count is only meaningful when this edge would actually count.
  assign bus.tc       = bus.enable & ~bus.clear & ~bus.load &
                        ((bus.up & at_max) | (~bus.up & at_min));
endmodule
